// File: rtl/alu_pkg.sv
// Shared ALU control encodings, sequencer state encoding and default datapath width.
package alu_pkg;
  localparam int WIDTH_DEF = 32;

  // {A_invert, B_invert, operation[1:0]}
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;
endpackage

// File: rtl/alu_mdu_ctrl_if.sv
// Request/response and shared-ALU signals of the multiply/divide sequencer.
interface alu_mdu_ctrl_if #(
  parameter int WIDTH = alu_pkg::WIDTH_DEF
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_src1;
  logic [WIDTH-1:0] alu_src2;
  logic [3:0]       alu_ctrl;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  // slave = the sequencer; master = requester plus the shared ALU
  modport slave (
    input  start, op, src_a, src_b, alu_result, alu_cout,
    output alu_src1, alu_src2, alu_ctrl, alu_cin, busy, done, hi, lo, div_zero
  );
  modport master (
    output start, op, src_a, src_b, alu_result, alu_cout,
    input  alu_src1, alu_src2, alu_ctrl, alu_cin, busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/alu_mdu_ctrl.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) sequencer
// that borrows the shared ALU for one add or subtract per cycle.
module alu_mdu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic          clk_i,
  input  logic          rst_n,
  alu_mdu_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] src1, src2, t;
  logic [3:0]       ctrl;
  logic             cin;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      dz_q    <= dz_d;
    end
  end

  // Partial remainder shifted left by one, pulling in the next dividend bit.
  assign t = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    dz_d    = dz_q;
    ctrl    = ALU_ADD;
    cin     = 1'b0;
    src1    = '0;
    src2    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          b_d   = bus.src_b;
          hi_d  = '0;
          lo_d  = bus.src_a;
          dz_d  = 1'b0;
          cnt_d = '0;
          if (!bus.op)                state_d = ST_MUL;
          else if (bus.src_b != '0)   state_d = ST_DIV;
          else begin
            hi_d    = bus.src_a;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        src1 = hi_q;
        src2 = lo_q[0] ? b_q : '0;
        {hi_d, lo_d} = {bus.alu_cout, bus.alu_result, lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_DONE;
      end
      ST_DIV: begin
        ctrl = ALU_SUB;
        cin  = 1'b1;
        src1 = t;
        src2 = b_q;
        // hi msb set means the true shifted remainder exceeds WIDTH bits, so it always fits B.
        if (hi_q[WIDTH-1] | bus.alu_cout) begin
          hi_d = bus.alu_result;
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = t;
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.alu_src1 = src1;
  assign bus.alu_src2 = src2;
  assign bus.alu_ctrl = ctrl;
  assign bus.alu_cin  = cin;
  assign bus.busy     = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Scoreboard bench: behavioural ALU, arithmetic reference model, decoupled done monitor.
module tb_alu_mdu_ctrl;
  import alu_pkg::*;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mdu_ctrl_if #(.WIDTH(W)) bus();
  alu_mdu_ctrl #(.WIDTH(W)) dut (.clk_i(clk), .rst_n(rst_n), .bus(bus));

  // Shared ALU stand-in: invert controls then and/or/add/slt.
  logic [W-1:0] alu_a, alu_b;
  logic [W:0]   alu_sum;
  always_comb begin
    alu_a   = bus.alu_ctrl[3] ? ~bus.alu_src1 : bus.alu_src1;
    alu_b   = bus.alu_ctrl[2] ? ~bus.alu_src2 : bus.alu_src2;
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, bus.alu_cin};
    bus.alu_cout = alu_sum[W];
    case (bus.alu_ctrl[1:0])
      2'b00:   bus.alu_result = alu_a & alu_b;
      2'b01:   bus.alu_result = alu_a | alu_b;
      2'b10:   bus.alu_result = alu_sum[W-1:0];
      default: bus.alu_result = {{(W-1){1'b0}}, alu_sum[W-1]};
    endcase
  end

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           k;
    int           lat;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [63:0] p;
    e.dz = 1'b0;
    e.lat = W;
    e.k = 0;
    if (!op) begin
      p = 64'(a) * 64'(b);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      e.hi = a;
      e.lo = '1;
      e.dz = 1'b1;
      e.lat = 0;
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("hi", 64'(bus.hi), 64'(mon_e.hi));
        check("lo", 64'(bus.lo), 64'(mon_e.lo));
        check("div_zero", 64'(bus.div_zero), 64'(mon_e.dz));
        check("latency", 64'(cyc - mon_e.k), 64'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int g = 0;
    while ((bus.busy || bus.done) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("idle_timeout", 64'(g), 64'(0));
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    e = model(op, a, b);
    e.k = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Issue, count busy cycles until done; inj pulses stray starts mid-op and in DONE.
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input bit inj);
    int nb = 0;
    int g = 0;
    issue(op, a, b);
    if (inj) begin
      bus.op = 1'b1;
      bus.src_a = 32'd77;
      bus.src_b = 32'd3;
    end
    while (!bus.done && g < 200) begin
      if (bus.busy) nb++;
      bus.start = inj && (nb == 10);
      @(negedge clk);
      g++;
    end
    bus.start = 1'b0;
    if (g >= 200) check("done_timeout", 64'(g), 64'(0));
    check("busy_cycles", 64'(nb), 64'((op && b == 0) ? 0 : W));
    if (inj) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    logic op;
    int g;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    #12;
    check("rst_hi", 64'(bus.hi), 64'(0));
    check("rst_lo", 64'(bus.lo), 64'(0));
    check("rst_busy_done_dz", 64'({bus.busy, bus.done, bus.div_zero}), 64'(0));
    check("idle_alu_drive", {bus.alu_src1, bus.alu_src2}, 64'(0));
    check("idle_alu_ctrl", 64'({bus.alu_ctrl, bus.alu_cin}), 64'({ALU_ADD, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'd7, 32'd6, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 32'd100, 32'd7, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(1'b1, 32'd5, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("dz_held", 64'({bus.div_zero, bus.hi, bus.lo}), {31'd0, 1'b1, 32'd5, 32'hFFFF_FFFF});
    run_op(1'b0, 32'd3, 32'd4, 1'b0);
    run_op(1'b0, 32'd9, 32'd9, 1'b1);

    // Reset mid-divide: outputs clear immediately and the op is dropped.
    issue(1'b1, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hi_lo", {bus.hi, bus.lo}, 64'(0));
    check("midrst_busy_done_dz", 64'({bus.busy, bus.done, bus.div_zero}), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b1, 32'd12, 32'd4, 1'b0);

    for (int i = 0; i < 24; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = '0;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(op, a, b, 1'b0);
    end

    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("scoreboard_drain", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_mdu_ctrl.md
# alu_mdu_ctrl

Multi-cycle multiply/divide sequencer that drives the shared 32-bit ALU, which is built from 1-bit `alu_top` slices. It accepts one unsigned 32×32 multiply or 32/32 divide request at a time. It performs the operation as 32 single-cycle ALU add (shift-add) or subtract (restoring) steps, then returns a 64-bit result in `hi`/`lo`. It sits beside the ALU in the execute stage; the top level muxes the ALU inputs between this block and the normal datapath using `busy`.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the step count equals `WIDTH`.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  1  0 = unsigned multiply, 1 = unsigned divide.
- `src_a`  in  WIDTH  multiplicand or dividend; latched on start.
- `src_b`  in  WIDTH  multiplier or divisor; latched on start.
- `alu_src1`  out  WIDTH  ALU operand 1.
- `alu_src2`  out  WIDTH  ALU operand 2.
- `alu_ctrl`  out  4  {A_invert, B_invert, operation[1:0]}.
- `alu_cin`  out  1  carry-in to ALU bit 0.
- `alu_result`  in  WIDTH  ALU result.
- `alu_cout`  in  1  carry-out of ALU bit WIDTH-1.
- `busy`  out  1  high while the ALU is owned by this block.
- `done`  out  1  one-cycle completion pulse.
- `hi`  out  WIDTH  product[63:32] or remainder.
- `lo`  out  WIDTH  product[31:0] or quotient.
- `div_zero`  out  1  last divide had divisor 0; held until next start.

## Operation
- States: IDLE, MUL, DIV, DONE.
  - IDLE: on `start`, latch B=`src_b`, set hi=0, lo=`src_a`, clear `div_zero`, clear step counter.
  - If `op`=0, go to MUL.
  - If `op`=1 and `src_b`≠0, go to DIV.
  - If `op`=1 and `src_b`=0, set hi=`src_a`, lo=all-ones, `div_zero`=1, and go to DONE.
- MUL step:
  - Drive `alu_ctrl`=ADD (0010), `alu_cin`=0, `alu_src1`=hi, `alu_src2`= lo[0] ? B : 0.
  - Update {hi,lo} ← {alu_cout, alu_result, lo[WIDTH-1:1]}.
- DIV step:
  - Let t = {hi[WIDTH-2:0], lo[WIDTH-1]}.
  - Drive `alu_ctrl`=SUB (0110), `alu_cin`=1, `alu_src1`=t, `alu_src2`=B.
  - If hi[WIDTH-1] | alu_cout (no borrow): hi←alu_result, lo←{lo[WIDTH-2:0],1}.
  - Otherwise: hi←t, lo←{lo[WIDTH-2:0],0}.
- Counter: 0..WIDTH-1. On the step where counter = WIDTH-1, go to DONE.
- DONE: `done`=1 for exactly one cycle, then unconditionally return to IDLE.
- `start` in MUL, DIV or DONE is ignored and has no side effects. The requester waits for `busy`=0 and `done`=0 before asserting `start`.
- IDLE/DONE ALU drive: `alu_ctrl`=ADD, `alu_cin`=0, `alu_src1`=`alu_src2`=0.
- `hi`, `lo` and `div_zero` hold their values from DONE until the next accepted start.

## Timing
- Reset (async assert, any state including mid-step): state IDLE, counter 0, hi=0, lo=0, B=0, `busy`=0, `done`=0, `div_zero`=0.
- In-flight operations are discarded on reset; the first start after reset deasserts behaves normally.
- `busy` = (state is MUL or DIV). It is registered state decode and is high from the edge after start through the last step edge.
- Let start be sampled at edge k.
  - Step edges are k+1 … k+WIDTH.
  - `done` is high in the cycle after edge k+WIDTH, and results are valid in that same cycle.
  - Latency from start to done is WIDTH+1 cycles: 33 at default.
- Divide by zero: `done` is high in the cycle after edge k; `busy` never rises.
- ALU path is combinational: `alu_result`/`alu_cout` are consumed in the same cycle they are driven. Each step is exactly one cycle.
- A new start is accepted at the earliest in the cycle after `done`.

## Structure
- Shared package `alu_pkg` holds:
  - ALU control constants: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
  - The state encoding for IDLE/MUL/DIV/DONE.
  - The default `WIDTH`.
- No internal sub-module. The 32-bit ALU (array of `alu_top`) is instantiated at top level and shared, so no ALU copy lives inside this block.

## Test plan
- Multiply 7 × 6 → `done` 33 cycles after start; hi=0, lo=42; `busy` high for 32 cycles.
- Multiply FFFFFFFF × FFFFFFFF → hi=FFFFFFFE, lo=00000001.
- Divide 100 / 7 → lo=14, hi=2. Divide FFFFFFFF / 1 → lo=FFFFFFFF, hi=0, `div_zero`=0.
- Divide 5 / 0 → `done` 1 cycle after start, `busy` stays 0; lo=FFFFFFFF, hi=5, `div_zero`=1. The following multiply clears `div_zero`.
- Start 9 × 9; pulse `start` with different operands at step 10 and in the DONE cycle → both ignored, result lo=81. Then drop `rst_n` at step 10 of the next divide → all outputs 0 immediately. Then 12 / 4 → lo=3, hi=0.
